// File: rtl/fe_test_checker_if.sv
// Front-end sample stream: one-cycle valid strobe with 24-bit left/right samples.
interface fe_test_checker_if;
    logic        frontEnd_valid;
    logic [23:0] l_frontEnd_data;
    logic [23:0] r_frontEnd_data;

    modport master (output frontEnd_valid, output l_frontEnd_data, output r_frontEnd_data);
    modport slave  (input  frontEnd_valid, input  l_frontEnd_data, input  r_frontEnd_data);
endinterface

// File: rtl/fe_test_checker.sv
// Receive-side checker for the front-end test generator: rebuilds the expected
// pattern for the selected mode and reports lock, counts and the first bad sample.
module fe_test_checker #(
    parameter logic [23:0] IMP_VALUE = 24'h7fff00,
    parameter logic [23:0] NEG_VALUE = 24'h8000ff,
    parameter logic [23:0] TRI_CEIL  = 24'h7ffffe,
    parameter int unsigned ERR_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [3:0]       data_out_select,
    input  logic [7:0]       triangle_inc_reg,
    input  logic             err_clr,
    fe_test_checker_if.slave fe,
    output logic             locked,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_count,
    output logic [23:0]      sample_count,
    output logic [23:0]      first_bad_data,
    output logic [23:0]      first_bad_expect
);
    localparam int unsigned DW = 24;
    localparam int unsigned PW = 9;

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_TRACK} state_t;

    state_t          state, state_nxt;
    logic [3:0]      sel_q;
    logic            armed, armed_nxt;
    logic            dir_up, dir_up_nxt;
    logic [DW-1:0]   prev, prev_nxt;
    logic [PW-1:0]   period, period_nxt;
    logic [PW-1:0]   phase, phase_nxt;

    logic            locked_nxt, err_flag_nxt;
    logic [ERR_W-1:0] err_count_nxt;
    logic [DW-1:0]   sample_count_nxt, first_bad_data_nxt, first_bad_expect_nxt;

    logic [DW-1:0]   inc, l, r, up_sum, dn_dif, exp_val;
    logic            go_idle, sel_chg, chk, err, cnt_en;

    assign inc     = {3'b000, triangle_inc_reg, 13'b0};
    assign l       = fe.l_frontEnd_data;
    assign r       = fe.r_frontEnd_data;
    assign up_sum  = prev + inc;
    assign dn_dif  = prev - inc;
    assign go_idle = !run || (data_out_select == 4'd0);
    assign sel_chg = (data_out_select != sel_q);
    assign chk     = fe.frontEnd_valid && !go_idle && (state != S_IDLE) && !sel_chg;

    // State and pattern-tracking registers, plus registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            sel_q            <= '0;
            armed            <= 1'b0;
            dir_up           <= 1'b1;
            prev             <= '0;
            period           <= '0;
            phase            <= '0;
            locked           <= 1'b0;
            err_flag         <= 1'b0;
            err_count        <= '0;
            sample_count     <= '0;
            first_bad_data   <= '0;
            first_bad_expect <= '0;
        end else begin
            state            <= state_nxt;
            sel_q            <= data_out_select;
            armed            <= armed_nxt;
            dir_up           <= dir_up_nxt;
            prev             <= prev_nxt;
            period           <= period_nxt;
            phase            <= phase_nxt;
            locked           <= locked_nxt;
            err_flag         <= err_flag_nxt;
            err_count        <= err_count_nxt;
            sample_count     <= sample_count_nxt;
            first_bad_data   <= first_bad_data_nxt;
            first_bad_expect <= first_bad_expect_nxt;
        end
    end

    // Next state, pattern prediction and per-sample error decision
    always_comb begin
        state_nxt  = state;
        armed_nxt  = armed;
        dir_up_nxt = dir_up;
        prev_nxt   = prev;
        period_nxt = period;
        phase_nxt  = phase;
        exp_val    = '0;
        err        = 1'b0;
        if (go_idle) begin
            state_nxt = S_IDLE;
        end else if (state == S_IDLE || sel_chg) begin
            state_nxt = S_ACQ;
            armed_nxt = 1'b0;
        end else if (chk) begin
            err = (l != r);
            case (data_out_select)
                4'd3: begin
                    if (state == S_TRACK) begin
                        if (dir_up) begin
                            if (up_sum < TRI_CEIL) begin
                                exp_val = up_sum;
                            end else begin
                                exp_val    = dn_dif;
                                dir_up_nxt = 1'b0;
                            end
                        end else begin
                            if (dn_dif > inc) begin
                                exp_val = dn_dif;
                            end else begin
                                exp_val    = up_sum;
                                dir_up_nxt = 1'b1;
                            end
                        end
                        err      = err || (l != exp_val);
                        prev_nxt = l;
                    end else begin
                        exp_val = r;
                        if (!err) begin
                            prev_nxt  = l;
                            armed_nxt = 1'b1;
                            if (armed && l == up_sum) begin
                                dir_up_nxt = 1'b1;
                                state_nxt  = S_TRACK;
                            end else if (armed && l == dn_dif) begin
                                dir_up_nxt = 1'b0;
                                state_nxt  = S_TRACK;
                            end
                        end
                    end
                end
                4'd4: begin
                    // phase doubles as the impulse spacing counter while acquiring
                    if (state == S_TRACK) begin
                        exp_val   = (phase == period) ? IMP_VALUE : '0;
                        err       = err || (l != exp_val);
                        phase_nxt = (phase == period) ? PW'(1) : phase + PW'(1);
                    end else begin
                        exp_val = r;
                        if (!err) begin
                            if (!armed) begin
                                if (l == IMP_VALUE) begin
                                    armed_nxt = 1'b1;
                                    phase_nxt = '0;
                                end
                            end else if (phase == '1) begin
                                err       = 1'b1;
                                exp_val   = IMP_VALUE;
                            end else if (l == IMP_VALUE) begin
                                period_nxt = phase + PW'(1);
                                phase_nxt  = PW'(1);
                                state_nxt  = S_TRACK;
                            end else if (l == '0) begin
                                phase_nxt = phase + PW'(1);
                            end else begin
                                armed_nxt = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    exp_val = (data_out_select == 4'd1) ? IMP_VALUE :
                              (data_out_select == 4'd2) ? NEG_VALUE : '0;
                    if (state == S_TRACK) begin
                        err = err || (l != exp_val);
                    end else if (!err && l == exp_val) begin
                        state_nxt = S_TRACK;
                    end
                end
            endcase
            if (err) begin
                state_nxt = S_ACQ;
                armed_nxt = 1'b0;
            end
        end
    end

    // Result registers: clear has priority, counts saturate/wrap, first error sticks
    always_comb begin
        cnt_en               = chk && (state == S_TRACK);
        locked_nxt           = (state_nxt == S_TRACK);
        err_flag_nxt         = err_flag;
        err_count_nxt        = err_count;
        sample_count_nxt     = sample_count;
        first_bad_data_nxt   = first_bad_data;
        first_bad_expect_nxt = first_bad_expect;
        if (err_clr) begin
            err_flag_nxt     = err;
            err_count_nxt    = err ? ERR_W'(1) : '0;
            sample_count_nxt = cnt_en ? DW'(1) : '0;
        end else begin
            if (cnt_en) begin
                sample_count_nxt = sample_count + DW'(1);
            end
            if (err) begin
                err_flag_nxt = 1'b1;
                if (err_count != '1) begin
                    err_count_nxt = err_count + ERR_W'(1);
                end
            end
        end
        if (err && (err_clr || !err_flag)) begin
            first_bad_data_nxt   = l;
            first_bad_expect_nxt = exp_val;
        end
    end
endmodule

// File: tb/tb_fe_test_checker.sv
// Directed self-checking bench for fe_test_checker with hand-computed expectations.
module tb_fe_test_checker;
    localparam logic [23:0] IMP = 24'h7fff00;
    localparam logic [23:0] NEG = 24'h8000ff;

    logic        clk = 1'b0;
    logic        reset_n, run, err_clr;
    logic [3:0]  sel;
    logic [7:0]  tri_inc;
    logic        locked, err_flag;
    logic [15:0] err_count;
    logic [23:0] sample_count, fbd, fbe;
    int          n_cmp = 0;
    int          n_bad = 0;

    fe_test_checker_if bus();

    fe_test_checker dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .run              (run),
        .data_out_select  (sel),
        .triangle_inc_reg (tri_inc),
        .err_clr          (err_clr),
        .fe               (bus),
        .locked           (locked),
        .err_flag         (err_flag),
        .err_count        (err_count),
        .sample_count     (sample_count),
        .first_bad_data   (fbd),
        .first_bad_expect (fbe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [23:0] l, input logic [23:0] r);
        @(negedge clk);
        bus.frontEnd_valid  = 1'b1;
        bus.l_frontEnd_data = l;
        bus.r_frontEnd_data = r;
        @(negedge clk);
        bus.frontEnd_valid  = 1'b0;
    endtask

    // Triangle sample k*0x20000 (inc for triangle_inc_reg=0x10)
    task automatic tri_send(input int k);
        logic [23:0] v;
        v = 24'(k << 17);
        send(v, v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_err_flag"}, 32'(err_flag), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_sample_count"}, 32'(sample_count), 32'd0);
        check({tag, "_first_bad_data"}, 32'(fbd), 32'd0);
        check({tag, "_first_bad_expect"}, 32'(fbe), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; sel = 4'd0; tri_inc = 8'd0; err_clr = 1'b0;
        bus.frontEnd_valid = 1'b0; bus.l_frontEnd_data = '0; bus.r_frontEnd_data = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Mode 1: constant +DC
        reset_n = 1'b1; run = 1'b1; sel = 4'd1;
        @(negedge clk);
        send(IMP, IMP);
        check("m1_lock_first", 32'(locked), 32'd1);
        repeat (9) send(IMP, IMP);
        check("m1_sample_count", 32'(sample_count), 32'd9);
        check("m1_err_count", 32'(err_count), 32'd0);
        check("m1_locked", 32'(locked), 32'd1);

        // Mode 3: triangle through two peaks and one trough
        @(negedge clk); sel = 4'd3; tri_inc = 8'h10; err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("m3_sel_unlock", 32'(locked), 32'd0);
        check("m3_clr_count", 32'(sample_count), 32'd0);
        tri_send(0);
        check("m3_seed_nolock", 32'(locked), 32'd0);
        tri_send(1);
        check("m3_lock", 32'(locked), 32'd1);
        for (int k = 2; k <= 63; k++) tri_send(k);
        for (int k = 62; k >= 2; k--) tri_send(k);
        check("m3_after_peak_err", 32'(err_count), 32'd0);
        for (int k = 3; k <= 63; k++) tri_send(k);
        check("m3_after_trough_err", 32'(err_count), 32'd0);
        for (int k = 62; k >= 61; k--) tri_send(k);
        check("m3_sweep_err", 32'(err_count), 32'd0);
        check("m3_sweep_locked", 32'(locked), 32'd1);
        check("m3_sweep_count", 32'(sample_count), 32'd186);
        send(24'h123456, 24'h123456);
        check("m3_inj_err_count", 32'(err_count), 32'd1);
        check("m3_inj_err_flag", 32'(err_flag), 32'd1);
        check("m3_inj_bad_data", 32'(fbd), 32'h123456);
        check("m3_inj_bad_expect", 32'(fbe), 32'h780000);
        check("m3_inj_unlock", 32'(locked), 32'd0);
        check("m3_inj_count", 32'(sample_count), 32'd187);
        tri_send(59);
        check("m3_reseed_nolock", 32'(locked), 32'd0);
        tri_send(58);
        check("m3_relock", 32'(locked), 32'd1);

        // Select 3 -> 1 mid-stream
        @(negedge clk); sel = 4'd1;
        @(negedge clk);
        check("sel_chg_unlock", 32'(locked), 32'd0);
        send(IMP, IMP);
        check("sel_chg_relock", 32'(locked), 32'd1);
        check("sel_chg_err_hold", 32'(err_count), 32'd1);

        // Mode 4: impulse every 12 samples, impulse 24 dropped
        @(negedge clk); sel = 4'd4; err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        for (int k = 0; k <= 48; k++) begin
            if ((k % 12 == 0) && (k != 24)) send(IMP, IMP);
            else send(24'd0, 24'd0);
            if (k == 0)  check("m4_first_imp_nolock", 32'(locked), 32'd0);
            if (k == 12) check("m4_lock", 32'(locked), 32'd1);
            if (k == 23) check("m4_tracking_err", 32'(err_count), 32'd0);
            if (k == 24) begin
                check("m4_drop_err_count", 32'(err_count), 32'd1);
                check("m4_drop_unlock", 32'(locked), 32'd0);
                check("m4_drop_bad_expect", 32'(fbe), 32'(IMP));
                check("m4_drop_bad_data", 32'(fbd), 32'd0);
            end
            if (k == 47) check("m4_reacq_nolock", 32'(locked), 32'd0);
            if (k == 48) begin
                check("m4_relock", 32'(locked), 32'd1);
                check("m4_relock_err", 32'(err_count), 32'd1);
            end
        end

        // Mode 2 with R off by one
        @(negedge clk); sel = 4'd2; err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(NEG, 24'h8000fe);
            check("m2_never_locked", 32'(locked), 32'd0);
        end
        check("m2_err_count", 32'(err_count), 32'd5);
        check("m2_bad_data", 32'(fbd), 32'(NEG));
        check("m2_bad_expect", 32'(fbe), 32'(NEG));

        // err_clr coincident with an erroring sample, then saturation
        @(negedge clk);
        err_clr = 1'b1; bus.frontEnd_valid = 1'b1;
        bus.l_frontEnd_data = NEG; bus.r_frontEnd_data = 24'h8000fe;
        @(negedge clk);
        err_clr = 1'b0; bus.frontEnd_valid = 1'b0;
        check("clr_coinc_err_count", 32'(err_count), 32'd1);
        check("clr_coinc_err_flag", 32'(err_flag), 32'd1);
        @(negedge clk); bus.frontEnd_valid = 1'b1;
        repeat (65540) @(negedge clk);
        bus.frontEnd_valid = 1'b0;
        check("sat_err_count", 32'(err_count), 32'hffff);
        repeat (3) send(NEG, 24'h8000fe);
        check("sat_err_hold", 32'(err_count), 32'hffff);
        check("sat_err_flag", 32'(err_flag), 32'd1);

        // run falling mid-TRACK, then async reset mid-TRACK
        @(negedge clk); sel = 4'd1;
        repeat (3) send(IMP, IMP);
        check("rf_lock", 32'(locked), 32'd1);
        check("rf_count", 32'(sample_count), 32'd2);
        @(negedge clk); run = 1'b0;
        @(negedge clk);
        check("rf_unlock", 32'(locked), 32'd0);
        send(IMP, IMP);
        check("rf_idle_count_hold", 32'(sample_count), 32'd2);
        check("rf_idle_err_hold", 32'(err_count), 32'hffff);
        run = 1'b1;
        @(negedge clk);
        send(IMP, IMP);
        check("rf_relock", 32'(locked), 32'd1);
        send(IMP, IMP);
        check("rf_count_resume", 32'(sample_count), 32'd3);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_locked", 32'(locked), 32'd0);
        check("post_rst_err_count", 32'(err_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
